// File: rtl/r_ctrl_pkg.sv
// Shared constants for the R-type controller: funct codes, ALU op codes and FSM states.
package r_ctrl_pkg;
    localparam logic [5:0] OPC_RTYPE  = 6'h00;

    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

    // Signed arithmetic ops are the only ones whose overflow is meaningful.
    function automatic logic is_addsub(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
    endfunction
endpackage

// File: rtl/r_funct_decode.sv
// Combinational opcode/funct decoder: maps a supported R-type funct to its ALU op code.
module r_funct_decode
    import r_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       legal
);
    always_comb begin
        alu_op = ALU_AND;
        legal  = (opcode == OPC_RTYPE);
        case (funct)
            FUNCT_ADD:  alu_op = ALU_ADD;
            FUNCT_SUB:  alu_op = ALU_SUB;
            FUNCT_AND:  alu_op = ALU_AND;
            FUNCT_OR:   alu_op = ALU_OR;
            FUNCT_XOR:  alu_op = ALU_XOR;
            FUNCT_NOR:  alu_op = ALU_NOR;
            FUNCT_SLTU: alu_op = ALU_SLTU;
            FUNCT_SLLV: alu_op = ALU_SLLV;
            default:    legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/r_instr_ctrl.sv
// Multi-cycle R-type controller: fetch over req/ack, decode, execute, single write-back.
// Optional build macro OF_TRAP_EN: overflowing ADD/SUB suppresses the write and sets illegal.
module r_instr_ctrl
    import r_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        inst_req,
    input  logic        inst_ack,
    input  logic [31:0] inst_data,
    output logic [31:0] pc,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic        rf_we,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        zf_q,
    output logic        of_q,
    output logic        illegal,
    output logic        busy
);
    state_t      state, state_next;
    logic [31:0] ir;
    logic [2:0]  dec_op;
    logic        dec_legal;
    logic        wb_trap;
    logic        unused_bits;

    r_funct_decode u_decode (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

`ifdef OF_TRAP_EN
    assign wb_trap = of_q && is_addsub(ir[5:0]);
`else
    assign wb_trap = 1'b0;
`endif

    // The result word and shamt field travel in the datapath; control never needs them.
    assign unused_bits = ^{alu_f, ir[10:6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run && !illegal) state_next = FETCH;
            FETCH:   if (inst_ack) state_next = DECODE;
            DECODE:  state_next = dec_legal ? EXEC : IDLE;
            EXEC:    state_next = WB;
            WB:      state_next = (run && !wb_trap) ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inst_req = (state == FETCH);
        rf_we    = (state == WB) && !wb_trap;
        busy     = (state != IDLE);
        rs_addr  = ir[25:21];
        rt_addr  = ir[20:16];
        rd_addr  = ir[15:11];
        alu_op   = dec_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_RESET;
            ir      <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: if (inst_ack) ir <= inst_data;
                DECODE: if (!dec_legal) begin
                    illegal <= 1'b1;
                    pc      <= pc + PC_STEP;
                end
                EXEC: begin
                    zf_q <= alu_zf;
                    of_q <= alu_of;
                end
                WB: begin
                    pc <= pc + PC_STEP;
                    if (wb_trap) illegal <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_r_instr_ctrl.sv
// Randomized self-checking bench for r_instr_ctrl against a transaction-level model.
module tb_r_instr_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        inst_ack = 1'b0;
    logic [31:0] inst_data = '0;
    logic [31:0] alu_f = '0;
    logic        alu_zf = 1'b0;
    logic        alu_of = 1'b0;
    logic        inst_req, rf_we, zf_q, of_q, illegal, busy;
    logic [31:0] pc;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [2:0]  alu_op;

    always #5 clk = ~clk;

    r_instr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_req(inst_req), .inst_ack(inst_ack),
        .inst_data(inst_data), .pc(pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rf_we(rf_we), .alu_op(alu_op), .alu_f(alu_f),
        .alu_zf(alu_zf), .alu_of(alu_of), .zf_q(zf_q), .of_q(of_q),
        .illegal(illegal), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model state and per-cycle expectations
    logic [31:0] m_pc = '0, m_ir = '0;
    logic        m_ill = 1'b0, m_zf = 1'b0, m_of = 1'b0;
    logic        e_valid = 1'b0, e_req, e_busy, e_we, e_fld, e_opchk;
    logic [2:0]  e_op;

    // Observation log
    int         we_cnt = 0, req_cnt = 0;
    logic [2:0] op_hist[$];
    logic [4:0] rs_last, rt_last, rd_last;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            we_cnt++;
            op_hist.push_back(alu_op);
            rs_last = rs_addr;
            rt_last = rt_addr;
            rd_last = rd_addr;
        end
        if (rst_n && inst_req) req_cnt++;
        if (e_valid) begin
            cmp("inst_req", 32'(inst_req), 32'(e_req));
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("rf_we", 32'(rf_we), 32'(e_we));
            cmp("pc", pc, m_pc);
            cmp("illegal", 32'(illegal), 32'(m_ill));
            cmp("zf_q", 32'(zf_q), 32'(m_zf));
            cmp("of_q", 32'(of_q), 32'(m_of));
            if (e_fld) begin
                cmp("rs_addr", 32'(rs_addr), 32'(m_ir[25:21]));
                cmp("rt_addr", 32'(rt_addr), 32'(m_ir[20:16]));
                cmp("rd_addr", 32'(rd_addr), 32'(m_ir[15:11]));
            end
            if (e_opchk) cmp("alu_op", 32'(alu_op), 32'(e_op));
        end
    end

    // {legal, alu_op} straight from the instruction-set table
    function automatic logic [3:0] ref_dec(input logic [31:0] w);
        if (w[31:26] != 6'h00) return 4'b0000;
        case (w[5:0])
            6'h20: return 4'b1100;
            6'h22: return 4'b1101;
            6'h24: return 4'b1000;
            6'h25: return 4'b1001;
            6'h26: return 4'b1010;
            6'h27: return 4'b1011;
            6'h2B: return 4'b1110;
            6'h04: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [5:0] funct_pick(input int k);
        case (k)
            0: return 6'h20; 1: return 6'h22; 2: return 6'h24; 3: return 6'h25;
            4: return 6'h26; 5: return 6'h27; 6: return 6'h2B; default: return 6'h04;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) return {6'($urandom_range(1, 63)), 26'($urandom())};
        if (r == 1) return {6'h00, 20'($urandom()), 6'h3F};
        return {6'h00, 20'($urandom()), funct_pick($urandom_range(0, 7))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic req, bsy, we, fld, opchk, input logic [2:0] op);
        e_valid = 1'b1; e_req = req; e_busy = bsy; e_we = we;
        e_fld = fld; e_opchk = opchk; e_op = op;
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_ill = 1'b0; m_zf = 1'b0; m_of = 1'b0;
    endtask

    task automatic do_reset();
        e_valid = 1'b0;
        rst_n = 1'b0; run = 1'b0; inst_ack = 1'b0;
        alu_zf = 1'b0; alu_of = 1'b0;
        tick();
        tick();
        model_reset();
        rst_n = 1'b1;
    endtask

    // One IDLE cycle with run raised; the DUT is in FETCH afterwards.
    task automatic start();
        run = 1'b1;
        expect_cyc(0, 0, 0, 0, 0, 3'b000);
        tick();
    endtask

    task automatic run_instr(input logic [31:0] w, input int wait_n, input logic zf, of,
                             input logic run_next, input logic abort_wb, output logic in_fetch);
        logic [3:0]  d;
        logic        trap;
        logic [31:0] pc0;
        d = ref_dec(w);
        pc0 = m_pc;
        for (int i = 0; i <= wait_n; i++) begin
            inst_ack  = (i == wait_n);
            inst_data = (i == wait_n) ? w : $urandom();
            expect_cyc(1, 1, 0, 0, 0, 3'b000);
            tick();
        end
        inst_ack = 1'b0;
        inst_data = $urandom();
        m_ir = w;
        run = run_next;
        expect_cyc(0, 1, 0, 1, d[3], d[2:0]);
        tick();
        if (!d[3]) begin
            m_ill = 1'b1;
            m_pc = m_pc + 32'd4;
            in_fetch = 1'b0;
            $display("instr pc=%08h word=%08h illegal wait=%0d", pc0, w, wait_n);
            return;
        end
        alu_zf = zf; alu_of = of; alu_f = $urandom();
        expect_cyc(0, 1, 0, 1, 1, d[2:0]);
        tick();
        m_zf = zf; m_of = of;
        trap = 1'b0;
`ifdef OF_TRAP_EN
        trap = of && (w[5:0] == 6'h20 || w[5:0] == 6'h22);
`endif
        expect_cyc(0, 1, !trap, 1, 1, d[2:0]);
        if (abort_wb) begin
            @(negedge clk);
            #2;
            e_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            cmp("wb reset rf_we", 32'(rf_we), 32'd0);
            cmp("wb reset pc", pc, 32'h0);
            cmp("wb reset busy", 32'(busy), 32'd0);
            cmp("wb reset inst_req", 32'(inst_req), 32'd0);
            model_reset();
            tick();
            rst_n = 1'b1;
            in_fetch = 1'b0;
            $display("instr pc=%08h word=%08h reset during write-back", pc0, w);
            return;
        end
        tick();
        m_pc = m_pc + 32'd4;
        if (trap) m_ill = 1'b1;
        in_fetch = run_next && !trap;
        $display("instr pc=%08h word=%08h op=%03b wait=%0d zf=%0d of=%0d run=%0d",
                 pc0, w, d[2:0], wait_n, zf, of, run_next);
    endtask

    logic       inf;
    int         base, b_we;
    logic [2:0] exp_ops[7];
    logic [5:0] fl[7];

    initial begin
        exp_ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        fl      = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h22, 6'h2B, 6'h04};

        // Reset state
        @(negedge clk);
        cmp("reset pc", pc, 32'h0);
        cmp("reset inst_req", 32'(inst_req), 32'd0);
        cmp("reset busy", 32'(busy), 32'd0);
        cmp("reset rf_we", 32'(rf_we), 32'd0);
        cmp("reset illegal", 32'(illegal), 32'd0);
        cmp("reset alu_op", 32'(alu_op), 32'd0);
        cmp("reset rd_addr", 32'(rd_addr), 32'd0);
        tick();
        model_reset();
        rst_n = 1'b1;

        // add $4,$2,$3 with a one-cycle ack latency
        start();
        run_instr(32'h00432020, 1, 1'b0, 1'b0, 1'b1, 1'b0, inf);
        cmp("t1 alu_op", 32'(op_hist[$]), 32'h4);
        cmp("t1 rs", 32'(rs_last), 32'd2);
        cmp("t1 rt", 32'(rt_last), 32'd3);
        cmp("t1 rd", 32'(rd_last), 32'd4);
        cmp("t1 pc", pc, 32'h4);

        // Stream of seven different ops from reset
        do_reset();
        start();
        base = op_hist.size();
        for (int i = 0; i < 7; i++)
            run_instr(rtype(5'($urandom()), 5'($urandom()), 5'($urandom()), fl[i]),
                      $urandom_range(0, 2), 1'($urandom()), 1'b0, 1'b1, 1'b0, inf);
        for (int i = 0; i < 7; i++)
            cmp($sformatf("t2 op%0d", i), 32'(op_hist[base + i]), 32'(exp_ops[i]));
        cmp("t2 pc", pc, 32'h1C);

        // Non-R opcode: illegal, no write, parked with run high
        do_reset();
        start();
        b_we = we_cnt;
        run_instr(32'h8C000000, 0, 1'b0, 1'b0, 1'b1, 1'b0, inf);
        for (int i = 0; i < 5; i++) begin
            expect_cyc(0, 0, 0, 0, 0, 3'b000);
            tick();
        end
        cmp("t3 illegal", 32'(illegal), 32'd1);
        cmp("t3 pc", pc, 32'h4);
        cmp("t3 busy", 32'(busy), 32'd0);
        cmp("t3 writes", 32'(we_cnt - b_we), 32'd0);

        // Slow memory: request held for six cycles
        do_reset();
        start();
        base = req_cnt;
        run_instr(rtype(5'd7, 5'd8, 5'd9, 6'h25), 5, 1'b1, 1'b0, 1'b0, 1'b0, inf);
        cmp("t4 req cycles", 32'(req_cnt - base), 32'd6);

        // Asynchronous reset while in write-back
        do_reset();
        start();
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h24), 0, 1'b0, 1'b0, 1'b1, 1'b1, inf);

        // Overflowing ADD
        do_reset();
        start();
        b_we = we_cnt;
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h20), 0, 1'b0, 1'b1, 1'b0, 1'b0, inf);
`ifdef OF_TRAP_EN
        cmp("t6 writes", 32'(we_cnt - b_we), 32'd0);
        cmp("t6 illegal", 32'(illegal), 32'd1);
`else
        cmp("t6 writes", 32'(we_cnt - b_we), 32'd1);
        cmp("t6 of_q", 32'(of_q), 32'd1);
        cmp("t6 illegal", 32'(illegal), 32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            if (!inf) begin
                if (m_ill) do_reset();
                run = 1'b0;
                for (int k = 0, g = $urandom_range(0, 2); k < g; k++) begin
                    expect_cyc(0, 0, 0, 0, 0, 3'b000);
                    tick();
                end
                start();
            end
            run_instr(rand_word(), $urandom_range(0, 3), 1'($urandom()), 1'($urandom()),
                      ($urandom_range(0, 4) != 0), 1'b0, inf);
        end

        e_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
